// File: rtl/huff_bit_packer.sv
// Huffman bit packer: holds the encoder's code table, maps each symbol to its
// variable-length code and packs the codes MSB-first into a byte stream.
module huff_bit_packer #(
    parameter int CHAR_COUNT = 3,
    parameter int CODE_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tbl_load,
    input  logic [CHAR_COUNT*8-1:0]      tbl_char,
    input  logic [CHAR_COUNT*CODE_W-1:0] tbl_value,
    input  logic [CHAR_COUNT*CODE_W-1:0] tbl_mask,
    input  logic                         sym_valid,
    output logic                         sym_ready,
    input  logic [7:0]                   sym_data,
    input  logic                         sym_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic [3:0]                   out_nbits,
    output logic                         sym_miss,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the producer holds its payload stable until then.

    localparam int ACC_W = 8 + CODE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        char_q  [CHAR_COUNT];
    logic [CODE_W-1:0] value_q [CHAR_COUNT];
    logic [CODE_W-1:0] mask_q  [CHAR_COUNT];
    logic [ACC_W-1:0]  acc;
    logic [3:0]        cnt;
    logic              miss_q;

    logic              hit;
    logic [CODE_W-1:0] hit_value;
    logic [3:0]        hit_len;
    logic              sym_fire;
    logic              out_fire;
    logic              load_ok;
    logic [7:0]        full_byte;
    logic [7:0]        pad_byte;

    function automatic logic [3:0] popcount(input logic [CODE_W-1:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + {3'b000, m[i]};
        end
        return n;
    endfunction

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        hit_value = '0;
        hit_len   = '0;
        for (int i = CHAR_COUNT - 1; i >= 0; i--) begin
            if (mask_q[i] != '0 && char_q[i] == sym_data) begin
                hit       = 1'b1;
                hit_value = value_q[i] & mask_q[i];
                hit_len   = popcount(mask_q[i]);
            end
        end
    end

    assign full_byte = 8'(acc >> (cnt - 4'd8));
    assign pad_byte  = 8'(acc << (4'd8 - cnt));

    assign sym_ready = (state == ST_READY || state == ST_RUN) && (cnt < 4'd8);
    assign sym_fire  = sym_valid && sym_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_ok   = tbl_load && (state == ST_IDLE || state == ST_READY);
    assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
    assign sym_miss  = miss_q;
    assign dbg_state = state;

    // FLUSH always ends on a byte flagged last; with nothing left to send
    // (cnt == 0) that byte is an empty 0x00 with nbits = 0.
    always_comb begin
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        out_nbits = 4'd0;
        case (state)
            ST_RUN: begin
                if (cnt >= 4'd8) begin
                    out_valid = 1'b1;
                    out_byte  = full_byte;
                    out_nbits = 4'd8;
                end
            end
            ST_FLUSH: begin
                out_valid = 1'b1;
                if (cnt >= 4'd8) begin
                    out_byte  = full_byte;
                    out_nbits = 4'd8;
                    out_last  = (cnt == 4'd8);
                end else begin
                    out_byte  = (cnt == 4'd0) ? 8'h00 : pad_byte;
                    out_nbits = cnt;
                    out_last  = 1'b1;
                end
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            miss_q <= 1'b0;
            for (int i = 0; i < CHAR_COUNT; i++) begin
                char_q[i]  <= '0;
                value_q[i] <= '0;
                mask_q[i]  <= '0;
            end
        end else begin
            miss_q <= sym_fire && !hit;

            if (load_ok) begin
                for (int i = 0; i < CHAR_COUNT; i++) begin
                    char_q[i]  <= tbl_char[i*8 +: 8];
                    value_q[i] <= tbl_value[i*CODE_W +: CODE_W];
                    mask_q[i]  <= tbl_mask[i*CODE_W +: CODE_W];
                end
                if (state == ST_IDLE) begin
                    state <= ST_READY;
                end
            end

            // Accept and emit are mutually exclusive (cnt < 8 vs cnt >= 8).
            if (sym_fire) begin
                if (hit) begin
                    acc <= (acc << hit_len) | {{(ACC_W-CODE_W){1'b0}}, hit_value};
                    cnt <= cnt + hit_len;
                end
                state <= sym_last ? ST_FLUSH : ST_RUN;
            end else if (out_fire) begin
                if (out_last) begin
                    state <= ST_READY;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 4'd8;
                end
            end
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Bench for huff_bit_packer: directed scenarios plus random packets, checked by
// a scoreboard fed from a bit-queue reference model.
module tb_huff_bit_packer;

    localparam int CC = 3;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tbl_load = 1'b0;
    logic [CC*8-1:0]  tbl_char = '0;
    logic [CC*CW-1:0] tbl_value = '0;
    logic [CC*CW-1:0] tbl_mask = '0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic [7:0]       sym_data = 8'h00;
    logic             sym_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_byte;
    logic             out_last;
    logic [3:0]       out_nbits;
    logic             sym_miss;
    logic             busy;
    logic [1:0]       dbg_state;

    huff_bit_packer #(.CHAR_COUNT(CC), .CODE_W(CW)) dut (
        .clk(clk), .reset(reset), .tbl_load(tbl_load), .tbl_char(tbl_char),
        .tbl_value(tbl_value), .tbl_mask(tbl_mask), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .out_nbits(out_nbits), .sym_miss(sym_miss),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass = 0;
    logic [12:0] exp_q[$];
    bit          pk_bits[$];
    logic [7:0]  m_char[CC];
    logic [2:0]  m_val[CC];
    logic [2:0]  m_mask[CC];
    int          exp_misses = 0;
    int          obs_misses = 0;
    bit          hold_low = 0;
    bit          rand_ready = 0;

    localparam logic [CC*8-1:0]  BASIC_CH  = {8'h63, 8'h62, 8'h61};
    localparam logic [CC*CW-1:0] BASIC_VAL = {3'b011, 3'b010, 3'b000};
    localparam logic [CC*CW-1:0] BASIC_MSK = {3'b011, 3'b011, 3'b001};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endfunction

    // ---------------- reference model ----------------
    function automatic void push_byte(input bit last, input int n);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[7-i] = pk_bits.pop_front();
        exp_q.push_back({last, 4'(n), b});
    endfunction

    function automatic void model_accept(input logic [7:0] c, input logic last);
        int idx;
        bit done;
        idx = -1;
        done = 0;
        for (int i = 0; i < CC; i++)
            if (idx < 0 && m_mask[i] != 3'b000 && m_char[i] == c) idx = i;
        if (idx < 0) exp_misses++;
        else for (int b = $countones(m_mask[idx]) - 1; b >= 0; b--) pk_bits.push_back(m_val[idx][b]);
        if (!last) begin
            while (pk_bits.size() >= 8) push_byte(0, 8);
        end else begin
            while (pk_bits.size() >= 8) begin
                done = (pk_bits.size() == 8);
                push_byte(done, 8);
            end
            if (pk_bits.size() > 0) push_byte(1, pk_bits.size());
            else if (!done) push_byte(1, 0);
        end
    endfunction

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [12:0] prev_out = '0;
    logic [12:0] got;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            got = {out_last, out_nbits, out_byte};
            if (sym_miss) obs_misses++;
            if (prev_stall) check("hold_stable", {out_valid, got}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got byte 0x%0h last %0d nbits %0d, none expected",
                             out_byte, out_last, out_nbits);
                end else begin
                    check("out_byte_last_nbits", got, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = got;
        end
    end

    // ---------------- sink ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_w(input logic [7:0] c, input logic last, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        sym_valid = 1'b1;
        sym_data = c;
        sym_last = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sym_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (ok) model_accept(c, last);
        else fail_now("sym_accept_timeout");
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_last = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int w;
        send_w(c, last, w);
    endtask

    task automatic load_table(input logic [CC*8-1:0] ch, input logic [CC*CW-1:0] val,
                              input logic [CC*CW-1:0] msk, input bit taken, input bit chk);
        tbl_char = ch;
        tbl_value = val;
        tbl_mask = msk;
        tbl_load = 1'b1;
        @(posedge clk);
        #1;
        tbl_load = 1'b0;
        if (taken) begin
            for (int i = 0; i < CC; i++) begin
                m_char[i] = ch[i*8 +: 8];
                m_val[i] = val[i*CW +: CW];
                m_mask[i] = msk[i*CW +: CW];
            end
        end
        if (chk) begin
            @(negedge clk);
            check("load_ready_next", sym_ready, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dbg_state == 2'd1) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
        check({name, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic basic_stream();
        send(8'h61, 0);
        check("busy_in_run", busy, 1);
        send(8'h62, 0);
        send(8'h63, 0);
        send(8'h61, 0);
        send(8'h62, 0);
        send(8'h63, 1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int  tw;
        int  w;
        bit  any;
        logic [CC*8-1:0]  rch;
        logic [CC*CW-1:0] rval;
        logic [CC*CW-1:0] rmsk;

        for (int i = 0; i < CC; i++) begin
            m_char[i] = '0;
            m_val[i] = '0;
            m_mask[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {sym_ready, out_valid, out_byte, out_last, out_nbits, sym_miss, busy, dbg_state}, 0);

        // symbols offered with no table loaded
        sym_valid = 1'b1;
        sym_data = 8'h61;
        any = 0;
        repeat (4) begin
            @(negedge clk);
            any |= sym_ready;
        end
        check("noload_ready", any, 0);
        sym_valid = 1'b0;
        @(posedge clk);
        #1;

        // basic packing
        load_table(BASIC_CH, BASIC_VAL, BASIC_MSK, 1, 1);
        basic_stream();
        wait_drain("basic_done");

        // exact fit with sink backpressure
        hold_low = 1;
        tw = 0;
        for (int i = 0; i < 8; i++) begin
            send_w(8'h61, (i == 7), w);
            tw += w;
        end
        check("exact_fit_no_stall", tw, 0);
        check("exact_fit_valid_noready", {out_valid, sym_ready}, 2'b10);
        any = 1;
        repeat (5) begin
            @(negedge clk);
            any &= out_valid && !out_ready;
        end
        check("backpressure_held", any, 1);
        hold_low = 0;
        wait_drain("exact_fit_done");

        // misses
        send(8'h62, 0);
        send(8'h7A, 0);
        check("miss_pulse", sym_miss, 1);
        send(8'h62, 1);
        check("miss_one_cycle", sym_miss, 0);
        wait_drain("miss_done");
        send(8'h7A, 1);
        wait_drain("all_miss_done");
        check("miss_count_directed", obs_misses, exp_misses);

        // table load during a packet is ignored
        send(8'h62, 0);
        load_table({8'h63, 8'h62, 8'h61}, {3'b001, 3'b111, 3'b001}, {3'b001, 3'b111, 3'b001}, 0, 0);
        send(8'h63, 0);
        send(8'h61, 1);
        wait_drain("run_load_done");

        // duplicate char: lowest index wins
        load_table({8'h61, 8'h62, 8'h61}, {3'b010, 3'b000, 3'b001}, {3'b111, 3'b011, 3'b001}, 1, 1);
        send(8'h61, 0);
        send(8'h61, 0);
        send(8'h62, 1);
        wait_drain("dup_done");

        // reset in the middle of a packet
        load_table(BASIC_CH, BASIC_VAL, BASIC_MSK, 1, 1);
        send(8'h61, 0);
        send(8'h62, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pk_bits.delete();
        for (int i = 0; i < CC; i++) m_mask[i] = '0;
        @(negedge clk);
        check("midreset_outputs",
              {sym_ready, out_valid, out_byte, out_last, out_nbits, sym_miss, busy, dbg_state}, 0);
        any = 0;
        repeat (4) begin
            @(negedge clk);
            any |= out_valid;
        end
        check("midreset_no_byte", any, 0);
        @(posedge clk);
        #1;
        load_table(BASIC_CH, BASIC_VAL, BASIC_MSK, 1, 1);
        basic_stream();
        wait_drain("after_reset_done");

        // random tables and packets under random backpressure
        rand_ready = 1;
        for (int p = 0; p < 30; p++) begin
            if (p % 6 == 0) begin
                for (int i = 0; i < CC; i++) begin
                    int len;
                    len = $urandom_range(0, 3);
                    rch[i*8 +: 8] = 8'($urandom_range(8'h41, 8'h44));
                    rmsk[i*CW +: CW] = 3'((1 << len) - 1);
                    rval[i*CW +: CW] = 3'($urandom) & rmsk[i*CW +: CW];
                end
                load_table(rch, rval, rmsk, 1, 1);
            end
            begin
                int n;
                n = $urandom_range(1, 12);
                for (int s = 0; s < n; s++)
                    send(8'($urandom_range(8'h40, 8'h45)), (s == n - 1));
            end
            wait_drain("random_done");
        end
        rand_ready = 0;
        check("miss_count_total", obs_misses, exp_misses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/huff_bit_packer.md
# huff_bit_packer

Downstream stage of the Huffman encoder. It latches the per-character code table the encoder produces on `done` (characters, encoded values, encoded masks) and then accepts a stream of 8-bit symbols. Each symbol is replaced by its variable-length code, and the codes are packed MSB-first into bytes on a valid/ready output stream. The last byte of a packet is zero-padded and carries a valid-bit count.

## Interface
- `CHAR_COUNT`, default 3, number of table entries; matches the encoder's `MAX_CHAR_COUNT`.
- `CODE_W`, default 3, code width in bits; equals `CHAR_COUNT`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `tbl_load`  in  1  one-cycle pulse; samples the table inputs.
- `tbl_char`  in  CHAR_COUNT×8  character per entry.
- `tbl_value`  in  CHAR_COUNT×CODE_W  code bits, right-aligned; bit len-1 is sent first.
- `tbl_mask`  in  CHAR_COUNT×CODE_W  contiguous low ones; code length = popcount.
- `sym_valid`  in  1  symbol present.
- `sym_ready`  out  1  symbol accepted when `sym_valid` and `sym_ready` are both high.
- `sym_data`  in  8  symbol character.
- `sym_last`  in  1  marks the final symbol of a packet.
- `out_valid`  out  1  byte present.
- `out_ready`  in  1  sink accepts.
- `out_byte`  out  8  packed bits; the first code bit is bit 7.
- `out_last`  out  1  final byte of the packet.
- `out_nbits`  out  4  valid bits in `out_byte` (0–8); 8 on every non-last byte.
- `sym_miss`  out  1  one-cycle pulse when an accepted symbol has no table match.
- `busy`  out  1  high while a packet is in progress.

## Operation
- **States:** IDLE (no table), READY (table held, no packet), RUN (packet open), FLUSH (last symbol taken, draining).
- **Table load:**
  - `tbl_load` is honoured in IDLE and in READY, and moves the state to READY.
  - It is ignored in RUN and FLUSH.
  - An entry with mask 0 is invalid and never matches.
- **Lookup:**
  - The lowest-index valid entry whose char equals `sym_data` is selected.
  - No match → pulse `sym_miss`, append no bits. The symbol is still consumed, including its `sym_last`.
- **Accumulator:** `acc` is 11 bits, `cnt` is 4 bits and holds 0–10 valid bits, stored right-aligned.
  - On accept: `acc ← (acc << len) | value`, `cnt ← cnt + len`.
- **Byte emit:**
  - While `cnt ≥ 8`: `out_valid = 1`, `out_byte = acc[cnt-1 -: 8]`.
  - On handshake, `cnt ← cnt − 8`.
- **`sym_ready`** = (state ∈ {READY, RUN}) and `cnt < 8`. It is 0 in IDLE and FLUSH.
- **State transitions:**
  - READY → RUN on the first accepted symbol without `sym_last`.
  - An accept with `sym_last` (from READY or RUN) → FLUSH.
- **FLUSH:**
  - Full bytes (`cnt ≥ 8`) drain first. `out_last` is asserted on a byte taken with `cnt == 8` exactly, with `out_nbits = 8`.
  - Then, if `0 < cnt < 8`: emit `{acc[cnt-1:0], zeros}` with `out_last = 1` and `out_nbits = cnt`.
  - If the packet produced no bits at all (every symbol missed): emit `0x00` with `out_last = 1` and `out_nbits = 0`.
  - Handshake of the last byte → READY, `acc` and `cnt` cleared, table retained.
- **Overflow:** none is possible. A symbol is accepted only when `cnt ≤ 7`, so `cnt ≤ 10` after any append.

## Timing
- **Reset values:** state IDLE, table cleared (all entries invalid), `acc = 0`, `cnt = 0`, and all outputs 0: `sym_ready`, `out_valid`, `out_byte`, `out_last`, `out_nbits`, `sym_miss`, `busy`.
- **Reset mid-packet:** aborts immediately. No `out_last` byte is emitted, and the table must be reloaded.
- **Table load:** a table loaded at cycle T gives `sym_ready = 1` at T+1.
- **Symbol latency:** a symbol accepted at cycle N is reflected in `cnt` at N+1. If that brings `cnt ≥ 8`, `out_valid = 1` at N+1 and `sym_ready = 0` at N+1.
- **Output stability:** all outputs are registered or decoded from registers. `out_byte`, `out_last` and `out_nbits` stay stable while `out_valid && !out_ready`.
- **Same-cycle accept and emit:** cannot occur, because `sym_ready` requires `cnt < 8` while `out_valid` requires `cnt ≥ 8`.
- **Throughput:** one symbol per cycle while `cnt < 8`. One byte per cycle while draining.
- **`sym_miss`:** asserted the cycle after the miss is accepted, for exactly one cycle.

## Test plan
- **Basic packing.** Table a=0x61 (value 0b000, mask 0b001), b=0x62 (value 0b010, mask 0b011), c=0x63 (value 0b011, mask 0b011). Stream a,b,c,a,b,c with last on the final c → bytes 0x5A (last=0, nbits=8), then 0xC0 (last=1, nbits=2). Return to READY.
- **Exact-fit and backpressure.** Same table, eight 'a' symbols with last, `out_ready` held low for 5 cycles → `sym_ready` stays 1 for all 8 accepts. A single byte 0x00 is then presented with last=1, nbits=8, held stable until `out_ready` rises.
- **Miss.** Stream b, 0x7A, b with last → `sym_miss` pulses once. Output is a single byte 0xA0 with last=1, nbits=4. A stream of only 0x7A with last → 0x00 with last=1, nbits=0.
- **Table guard.**
  - Symbols before any `tbl_load` → `sym_ready = 0`.
  - A `tbl_load` issued in RUN with a different table is ignored; the remaining symbols still use the old codes.
  - A duplicate char in entries 0 and 2 → entry 0's code is used.
- **Reset mid-operation.** Accept a,b, then assert `reset` for 1 cycle → all outputs 0, state IDLE, no byte emitted. After a reload, the basic packing scenario reproduces 0x5A/0xC0.
